// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: mixes COLS_PER_CYCLE columns per clock through shared column
// mixers, with a per-block bypass for the final cipher round.
module mix_columns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LastCol = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q;
    logic [1:0]          col_q;
    logic [3:0][31:0]    work_q;
    logic [3:0][31:0]    work_d;
    logic [127:0]        out_state_q;
    logic                out_valid_q;
    logic                accept;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column word holds row 0 in its top byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        r3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return {r0, r1, r2, r3};
    endfunction

    // Column 0 sits in the most significant word, so column c lives in slot 3-c.
    function automatic logic [1:0] slot(input logic [1:0] c);
        return ~c;
    endfunction

    assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;

    always_comb begin
        work_d = work_q;
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
            work_d[slot(col_q + 2'(k))] = mix_col(work_q[slot(col_q + 2'(k))]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            col_q       <= 2'd0;
            work_q      <= '0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                state_q     <= StDone;
                out_state_q <= in_state;
                out_valid_q <= 1'b1;
            end else begin
                state_q     <= StBusy;
                col_q       <= 2'd0;
                work_q      <= in_state;
                out_valid_q <= 1'b0;
            end
        end else begin
            unique case (state_q)
                StBusy: begin
                    work_q <= work_d;
                    col_q  <= col_q + ColStep;
                    if (col_q == LastCol) begin
                        state_q     <= StDone;
                        out_state_q <= work_d;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Sequential AES MixColumns stage, placed directly downstream of shiftRows in the cipher round datapath.
- Accepts one 128-bit AES state per handshake and processes COLS_PER_CYCLE columns per clock through shared GF(2^8) column mixers.
- Presents the mixed state on a valid/ready output.
- A per-block bypass flag (final cipher round) passes the state through unmixed.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_state/in_last are valid
- in_ready  output  1  block can accept input this cycle
- in_state  input  128  state; byte state[c][r] (column c, row r) at bits [127-32c-8r -: 8]
- in_last  input  1  1 = final round: bypass MixColumns
- out_valid  output  1  out_state is valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  result, same byte mapping as in_state

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE; column counter = 0; out_valid = 0; out_state = 0.
  - Any in-flight block is discarded without output.
  - rst takes priority over every other event in that cycle.
- FSM states: IDLE, BUSY, DONE. Let N = 4/COLS_PER_CYCLE.
- Output driving:
  - in_ready = (FSM==IDLE) | (FSM==DONE & out_ready).
  - out_valid = (FSM==DONE).
- Accept: a transfer happens when in_valid & in_ready. The block captures in_state into a work register and latches in_last.
  - in_last=0: go to BUSY with col=0.
  - in_last=1: go to DONE with out_state = in_state unchanged.
- BUSY: each cycle, mix columns col .. col+COLS_PER_CYCLE-1 in place and advance col by COLS_PER_CYCLE.
  - The cycle that processes the last column goes to DONE and loads out_state.
  - When COLS_PER_CYCLE=4, BUSY lasts exactly 1 cycle.
- Latency from accept edge to out_valid=1:
  - mix: N cycles (4, 2 or 1).
  - bypass: 1 cycle.
- DONE: out_state and out_valid are held stable while out_ready=0.
  - out_ready=1 and no new accept: go to IDLE next cycle.
  - out_ready=1 with in_valid=1: output transfer and new accept in the same cycle; next state follows the accept rules above. No bubble.
- in_valid while BUSY: ignored (in_ready=0). The upstream must hold its data.
- Column math, bytes a0..a3 = rows 0..3:
  - xt(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00)
  - r0 = xt(a0)^xt(a1)^a1^a2^a3
  - r1 = a0^xt(a1)^xt(a2)^a2^a3
  - r2 = a0^a1^xt(a2)^xt(a3)^a3
  - r3 = xt(a0)^a0^a1^a2^xt(a3)
  - All arithmetic is 8-bit XOR; there are no carries.
- in_state and in_last are sampled only on an accept edge. Changes while not accepted have no effect.

Test Plan:
- Reset check: assert rst for 2 cycles → in_ready=1, out_valid=0, out_state=0. Then assert rst in the middle of BUSY → the next cycle is IDLE and no out_valid pulse ever appears for the aborted block.
- Known columns (COLS_PER_CYCLE=1), in_last=0, in_state columns:
  - input: db135345, f20a225c, 01010101, c6c6c6c6
  - required out_state columns: 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6
  - required timing: out_valid exactly 4 cycles after accept.
- FIPS-197 round-1 state, after shiftRows, columns d4bf5d30, e0b452ae, b84111f1, 1e2798e5 → out_state 046681e5, e0cb199a, 48f8d37a, 2806264c. Repeat with COLS_PER_CYCLE=2 and 4 → identical data, latency 2 and 1.
- Bypass: in_last=1, any state (e.g. 00112233_44556677_8899aabb_ccddeeff) → out_state identical, out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_state and out_valid stable, in_ready=0. Raise out_ready with in_valid=1 → both transfers occur in the same cycle, and the second block's result appears after N more cycles.
- Ignored input: toggle in_valid and in_state while BUSY → no effect on the result. The next block is accepted only when in_ready=1.
